mul_pipe_vr: RTL



---
 rtl/mul_pipe_pkg.sv | 56 +++++
 rtl/mul_pipe_vr_if.sv | 33 +++
 rtl/mul_pipe_stage.sv | 59 +++++
 rtl/mul_pipe_vr.sv | 103 ++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared definitions for the mul_pipe_vr multiplier slice.
// - prod_width(): exact signed product width for two operands, each widened by one bit.
// - round_shift_sat(): round-half-up, arithmetic right shift and clamp to the output range.
// - LatMax: largest supported pipeline depth.
package mul_pipe_pkg;

  localparam int unsigned LatMax = 8;

  // Wide enough for any supported product plus the rounding carry.
  localparam int unsigned CalcW = 128;

  typedef logic signed [CalcW-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  sat;
  } rss_t;

  function automatic int unsigned prod_width(int unsigned a_w, int unsigned b_w);
    return a_w + b_w + 2;
  endfunction

  function automatic rss_t round_shift_sat(calc_t p, int unsigned shift, bit do_round,
                                           int unsigned out_w, bit out_signed);
    calc_t one;
    calc_t r;
    calc_t q;
    calc_t hi;
    calc_t lo;
    rss_t  res;
    one = calc_t'(1);
    r   = p;
    if (do_round && (shift > 0)) begin
      r = p + (one <<< (shift - 1));
    end
    q = r >>> shift;
    if (out_signed) begin
      hi = (one <<< (out_w - 1)) - one;
      lo = -hi - one;
    end else begin
      hi = (one <<< out_w) - one;
      lo = '0;
    end
    res.value = q;
    res.sat   = 1'b0;
    if (q > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (q < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/mul_pipe_vr_if.sv
// Valid/ready stream bundle for mul_pipe_vr.
// Input side: in_valid/in_ready, operands a/b with per-sample sign flags, in_tag.
// Output side: out_valid/out_ready, result, out_tag, out_sat.
// Modport slave is the multiplier's view; master is the producer/consumer view.
interface mul_pipe_vr_if #(
  parameter int unsigned A_W   = 10,
  parameter int unsigned B_W   = 18,
  parameter int unsigned OUT_W = 28,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             a_signed;
  logic             b_signed;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             out_sat;

  modport slave (
    input  in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag, out_sat
  );

  modport master (
    output in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag, out_sat
  );
endinterface

// File: rtl/mul_pipe_stage.sv
// One pipeline register slice: valid bit, accept logic, data and tag registers.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   v_prev_i          valid of the upstream stage (or in_valid for the first slice)
//   acc_next_i        accept of the downstream stage (or out_ready for the last slice)
//   data_i, tag_i     payload offered by upstream
//   v_o, acc_o        this slice's valid and accept
//   data_o, tag_o     registered payload
module mul_pipe_stage #(
  parameter int unsigned DataW = 8,
  parameter int unsigned TagW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             v_prev_i,
  input  logic             acc_next_i,
  input  logic [DataW-1:0] data_i,
  input  logic [TagW-1:0]  tag_i,
  output logic             v_o,
  output logic             acc_o,
  output logic [DataW-1:0] data_o,
  output logic [TagW-1:0]  tag_o
);
  logic             v_d, v_q;
  logic [DataW-1:0] data_d, data_q;
  logic [TagW-1:0]  tag_d, tag_q;

  // An empty slice always accepts, so bubbles collapse.
  assign acc_o = !v_q | acc_next_i;

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    tag_d  = tag_q;
    if (acc_o) begin
      v_d = v_prev_i;
      if (v_prev_i) begin
        data_d = data_i;
        tag_d  = tag_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      data_q <= '0;
      tag_q  <= '0;
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      tag_q  <= tag_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign tag_o  = tag_q;
endmodule

// File: rtl/mul_pipe_vr.sv
// Pipelined signed/unsigned multiplier with valid/ready handshake, optional
// round-and-shift and output saturation.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          mul_pipe_vr_if slave: operand stream in, result stream out
// Slice s1 captures the exact product; round/shift/saturate is applied on entry
// to the last slice (directly on the product when LAT=1); middle slices only delay.
module mul_pipe_vr
  import mul_pipe_pkg::*;
#(
  parameter int unsigned A_W        = 10,
  parameter int unsigned B_W        = 18,
  parameter int unsigned OUT_W      = 28,
  parameter int unsigned LAT        = 2,
  parameter int unsigned SHIFT      = 0,
  parameter bit          ROUND      = 1'b0,
  parameter bit          OUT_SIGNED = 1'b0,
  parameter int unsigned TAG_W      = 4
) (
  input logic         clk,
  input logic         rst_n,
  mul_pipe_vr_if.slave bus
);
  localparam int unsigned PW = prod_width(A_W, B_W);

  if ((LAT < 1) || (LAT > LatMax)) begin : g_bad_lat
    $error("mul_pipe_vr: LAT=%0d outside 1..%0d", LAT, LatMax);
  end
  if (SHIFT > A_W + B_W) begin : g_bad_shift
    $error("mul_pipe_vr: SHIFT=%0d outside 0..%0d", SHIFT, A_W + B_W);
  end
  if ((PW + 1 > CalcW) || (OUT_W + 2 > CalcW)) begin : g_bad_width
    $error("mul_pipe_vr: operand/result widths exceed internal calc width");
  end

  logic signed [A_W:0]    a_ext;
  logic signed [B_W:0]    b_ext;
  logic signed [PW-1:0]   p_stage [LAT];
  logic [TAG_W-1:0]       tag     [LAT+1];
  logic                   v       [LAT+1];
  logic                   acc     [1:LAT+1];
  rss_t                   rss;
  logic [OUT_W:0]         fin_in;
  logic [OUT_W:0]         fin_q;
  logic                   unused_rss;

  assign a_ext = {bus.a_signed & bus.a[A_W-1], bus.a};
  assign b_ext = {bus.b_signed & bus.b[B_W-1], bus.b};

  // Both operands sign-extend to PW, so the low PW bits of the product are exact.
  assign p_stage[0] = PW'(a_ext) * PW'(b_ext);

  assign v[0]       = bus.in_valid;
  assign tag[0]     = bus.in_tag;
  assign acc[LAT+1] = bus.out_ready;

  assign rss        = round_shift_sat(calc_t'(p_stage[LAT-1]), SHIFT, ROUND, OUT_W, OUT_SIGNED);
  assign fin_in     = {rss.sat, rss.value[OUT_W-1:0]};
  // Clamped value always fits OUT_W; upper bits are sign/zero copies.
  assign unused_rss = ^rss.value[CalcW-1:OUT_W];

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    if (k == LAT) begin : g_last
      mul_pipe_stage #(
        .DataW (OUT_W + 1),
        .TagW  (TAG_W)
      ) u_stage (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .v_prev_i   (v[k-1]),
        .acc_next_i (acc[k+1]),
        .data_i     (fin_in),
        .tag_i      (tag[k-1]),
        .v_o        (v[k]),
        .acc_o      (acc[k]),
        .data_o     (fin_q),
        .tag_o      (tag[k])
      );
    end else begin : g_mid
      mul_pipe_stage #(
        .DataW (PW),
        .TagW  (TAG_W)
      ) u_stage (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .v_prev_i   (v[k-1]),
        .acc_next_i (acc[k+1]),
        .data_i     (p_stage[k-1]),
        .tag_i      (tag[k-1]),
        .v_o        (v[k]),
        .acc_o      (acc[k]),
        .data_o     (p_stage[k]),
        .tag_o      (tag[k])
      );
    end
  end

  assign bus.in_ready  = acc[1];
  assign bus.out_valid = v[LAT];
  assign bus.result    = fin_q[OUT_W-1:0];
  assign bus.out_sat   = fin_q[OUT_W];
  assign bus.out_tag   = tag[LAT];
endmodule
